// File: rtl/gpio_input_conditioner.sv
// Per-bit GPIO input conditioner: two-flop synchroniser, stable-time debounce,
// one-cycle rise/fall pulses and a sticky change flag with per-bit clear.
module gpio_input_conditioner #(
    parameter int                WIDTH         = 3,
    parameter int                STABLE_CYCLES = 500000,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] bypass,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] changed
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] deb_next;

    // Saturating increment: the count never runs past the acceptance point.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_LAST)
            return CNT_LAST;
        return c + CNT_W'(1);
    endfunction

    always_comb begin
        deb_next = debounced;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (bypass[i]) begin
                deb_next[i] = sync_p1[i];
            end else if (sync_p1[i] != debounced[i]) begin
                if (cnt[i] == CNT_LAST)
                    deb_next[i] = sync_p1[i];
                else
                    cnt_next[i] = cnt_inc(cnt[i]);
            end
        end
    end

    // Stage p0/p1: synchroniser; then debounce state, pulses and sticky flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0   <= RESET_VALUE;
            sync_p1   <= RESET_VALUE;
            debounced <= RESET_VALUE;
            rise      <= '0;
            fall      <= '0;
            changed   <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            sync_p0   <= pin_in;
            sync_p1   <= sync_p0;
            debounced <= deb_next;
            rise      <= deb_next & ~debounced;
            fall      <= ~deb_next & debounced;
            // A pending pulse takes priority over a clear in the same cycle.
            changed   <= rise | fall | (changed & ~clear);
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= cnt_next[i];
        end
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: fixed vector table, hand sequences for
// bypass and reset-mid-count, then randomized traffic against a timestamp model.
module tb_gpio_input_conditioner;

    localparam int          W      = 3;
    localparam int          STABLE = 4;
    localparam logic [2:0]  RV     = 3'b010;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] pin_in = '0;
    logic [W-1:0] bypass = '0;
    logic [W-1:0] clear = '0;
    logic [W-1:0] debounced, rise, fall, changed;

    int vectors = 0;
    int miscompares = 0;

    gpio_input_conditioner #(
        .WIDTH(W), .STABLE_CYCLES(STABLE), .RESET_VALUE(RV)
    ) dut (
        .clock(clock), .reset(reset), .pin_in(pin_in), .bypass(bypass),
        .clear(clear), .debounced(debounced), .rise(rise), .fall(fall),
        .changed(changed)
    );

    always #5 clock = ~clock;

    // Reference model: a bit accepts its synchronised level once it has
    // disagreed with the accepted level for STABLE consecutive edges, measured
    // from the edge stamp where the disagreement began.
    logic [W-1:0] m_s1, m_s2, m_deb, m_rise, m_fall, m_chg;
    int           m_start [W];
    int           m_t = 0;

    task automatic model_reset();
        m_s1 = RV; m_s2 = RV; m_deb = RV;
        m_rise = '0; m_fall = '0; m_chg = '0;
        for (int i = 0; i < W; i++) m_start[i] = -1;
    endtask

    task automatic model_step();
        logic [W-1:0] nd;
        nd = m_deb;
        for (int i = 0; i < W; i++) begin
            if (bypass[i]) begin
                nd[i] = m_s2[i];
                m_start[i] = -1;
            end else if (m_s2[i] == m_deb[i]) begin
                m_start[i] = -1;
            end else begin
                if (m_start[i] < 0) m_start[i] = m_t;
                if (m_t - m_start[i] + 1 >= STABLE) begin
                    nd[i] = m_s2[i];
                    m_start[i] = -1;
                end
            end
        end
        m_chg  = m_rise | m_fall | (m_chg & ~clear);
        m_rise = nd & ~m_deb;
        m_fall = ~nd & m_deb;
        m_deb  = nd;
        m_s2   = m_s1;
        m_s1   = pin_in;
        m_t++;
    endtask

    task automatic tick(input logic r, input logic [W-1:0] p, b, c);
        @(negedge clock);
        reset = r; pin_in = p; bypass = b; clear = c;
        @(posedge clock);
        if (r) model_step(); else model_reset();
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    typedef struct {
        logic       r;
        logic [2:0] p, b, c;
        logic [2:0] deb, ri, fa, ch;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] p, c,
                       input logic [2:0] deb, ri, fa, ch);
        vec_t v;
        v.r = r; v.p = p; v.b = 3'b000; v.c = c;
        v.deb = deb; v.ri = ri; v.fa = fa; v.ch = ch;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] rp, rb, rc;
        logic       rr;
        int         hold [W];
        logic       hist [int];
        logic       p2, d2, d2_prev;
        int         lat;

        model_reset();

        // Reset held with toggling pins, then release at RESET_VALUE.
        add(0, 3'b101, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
        add(0, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
        add(0, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++)
            add(1, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
        // Clean rise on bit0: sampled at row 6, accepted at row 11.
        for (int k = 0; k < 5; k++)
            add(1, 3'b011, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 3'b000, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1, 3'b011, 3'b000, 3'b011, 3'b000, 3'b000, 3'b001);
        add(1, 3'b011, 3'b001, 3'b011, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000);
        // Fall on bit0, with clear colliding with the pending set.
        for (int k = 0; k < 5; k++)
            add(1, 3'b010, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000);
        add(1, 3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000);
        add(1, 3'b010, 3'b001, 3'b010, 3'b000, 3'b000, 3'b001);
        add(1, 3'b010, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000);
        // Three-cycle glitch on bit1 is rejected.
        for (int k = 0; k < 3; k++)
            add(1, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++)
            add(1, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000);

        foreach (vecs[n]) begin
            tick(vecs[n].r, vecs[n].p, vecs[n].b, vecs[n].c);
            check($sformatf("table[%0d]", n), {debounced, rise, fall, changed},
                  {vecs[n].deb, vecs[n].ri, vecs[n].fa, vecs[n].ch});
        end

        // Bypass on bit2: pin toggles every 3 cycles, output lags by 2 edges.
        hist[-2] = 1'b0; hist[-1] = 1'b0;
        d2_prev = 1'b0;
        for (int k = 0; k < 18; k++) begin
            p2 = ((k / 3) % 2) == 1;
            hist[k] = p2;
            tick(1, {p2, 2'b10}, 3'b100, 3'b000);
            d2 = hist[k-2];
            check($sformatf("bypass[%0d]", k), {9'b0, debounced[2], rise[2], fall[2]},
                  {9'b0, d2, d2 & ~d2_prev, ~d2 & d2_prev});
            d2_prev = d2;
        end

        // Reset mid-count on bit0, then full latency again after release.
        for (int k = 0; k < 4; k++) tick(1, 3'b010, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++) tick(1, 3'b011, 3'b000, 3'b000);
        for (int k = 0; k < 2; k++) begin
            tick(0, 3'b011, 3'b000, 3'b000);
            check("reset_hold", {debounced, rise, fall, changed}, {3'b010, 9'b0});
        end
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            tick(1, 3'b011, 3'b000, 3'b000);
            if (lat < 0 && debounced[0]) lat = k;
        end
        check("reset_latency", 12'(lat), 12'd5);

        // Randomized traffic against the model.
        rp = pin_in; rb = '0;
        for (int i = 0; i < W; i++) hold[i] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < W; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    rp[i] = ~rp[i];
                    hold[i] = $urandom_range(1, 9);
                end
                if ($urandom_range(0, 39) == 0) rb[i] = ~rb[i];
            end
            rc = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rr = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick(rr, rp, rb, rc);
            check($sformatf("random[%0d]", n), {debounced, rise, fall, changed},
                  {m_deb, m_rise, m_fall, m_chg});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
